wb_regfile_unit: RTL and testbench
==================================

Name: wb_regfile_unit

Overview:
Writeback stage of the pipelined Y86-64 core. It consumes the W pipeline register outputs (stat, icode, valE, valM, dstE, dstM) and commits them into the 15-entry architectural register file. It provides the two combinational read ports used by decode, derives the processor status, and holds a sticky halted state. It also keeps a retired-instruction counter.

Parameters:
DATA_W, 64, register/data width
CNT_W, 32, width of retired-instruction counter
RSP_RESET, 0, reset value of %rsp (reg id 4); all other registers reset to 0

Ports:
clk  input  1  system clock, all state updates on posedge
rst_n  input  1  asynchronous active-low reset
W_stat  input  4  status of instruction in W: 1=AOK, 2=HLT, 3=ADR, 4=INS, 8=BUB (bubble)
W_icode  input  4  instruction code in W
W_valE  input  DATA_W  ALU result to write to W_dstE
W_valM  input  DATA_W  memory result to write to W_dstM
W_dstE  input  4  destination register for valE, 0xF = RNONE
W_dstM  input  4  destination register for valM, 0xF = RNONE
d_srcA  input  4  decode read address A, 0xF = RNONE
d_srcB  input  4  decode read address B, 0xF = RNONE
d_rvalA  output  DATA_W  register contents at d_srcA (combinational)
d_rvalB  output  DATA_W  register contents at d_srcB (combinational)
Stat  output  4  processor status (1/2/3/4 encoding)
halted  output  1  sticky: processor has stopped
retired  output  CNT_W  count of committed AOK instructions

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-halt): regs 0-14 = 0 except reg 4 = RSP_RESET; Stat=1 (AOK); halted=0; retired=0; FSM -> RUN.
- Reads: pure combinational from the array. srcX=0xF -> 0. No internal write-to-read bypass: a read in the same cycle as a write returns the old value. Decode forwards from W_valE/W_valM itself.
- FSM states RUN, HALTED.
- RUN, each posedge:
  - commit = (W_stat==1).
  - If commit and W_dstE!=0xF: reg[W_dstE] <= W_valE.
  - If commit and W_dstM!=0xF: reg[W_dstM] <= W_valM.
  - Same destination on both ports (e.g. popq %rsp): valM wins, valE is discarded.
  - If commit: retired <= retired+1, saturating at 2^CNT_W-1 (no wrap).
  - W_stat==8 (BUB): no writes, no count; Stat <= 1.
  - W_stat in {2,3,4}: no writes, no count; Stat <= W_stat; halted <= 1; -> HALTED.
  - W_stat==1: Stat <= 1.
  - Any other W_stat code is treated as INS (4), goes to HALTED.
- HALTED: all register writes, counting and Stat updates are blocked regardless of inputs. Stat and retired are frozen. Read ports remain functional. Exit only via reset.
- W_icode only qualifies status; it does not gate writes. A nop has dstE=dstM=0xF, writes nothing, but is counted when AOK.
- Latency: a write presented on cycle N is visible on d_rvalA/B after posedge N. Stat and halted update at the same edge.

Test Plan:
- Reset release, then W_stat=1, W_dstE=3, W_valE=0x1122334455667788, W_dstM=0xF -> after edge d_srcA=3 reads 0x1122334455667788; retired=1; Stat=1.
- W_stat=1, W_dstE=4, W_valE=0x100, W_dstM=4, W_valM=0x200 -> reg4=0x200; retired increments once.
- Same-cycle read: d_srcA=5 while writing reg5 old=0 -> new=0x55: d_rvalA=0 before edge, 0x55 after; d_srcB=0xF -> 0.
- Two BUB cycles (W_stat=8) with dstE=2 -> reg2 unchanged, retired unchanged, Stat=1. Then W_stat=2 with dstE=2, valE=0x9 -> reg2 unchanged, Stat=2, halted=1. Subsequent AOK writes are ignored and retired stays frozen.
- W_stat=3 (ADR) -> Stat=3, halted=1. Assert rst_n=0 asynchronously mid-cycle -> Stat=1, halted=0, regs cleared, reg4=RSP_RESET, immediately without waiting for a clock edge.
- CNT_W=4: apply 20 consecutive AOK nops -> retired counts to 15 and holds at 15.

Source files
------------

// File: rtl/wb_regfile_unit.sv
// Purpose : Y86-64 writeback stage. Commits W-stage results into the 15-entry
//           register file, derives processor status, holds a sticky halt and
//           counts retired instructions.
// Latency : writes, Stat, halted and retired update at the posedge after the
//           W inputs are presented. Read ports are combinational, with no
//           write-to-read bypass.
// Backpressure: none. The W stage is consumed every cycle. Once halted, all
//           commits are dropped until reset.
// Ports   : clk/rst_n            clock and async active-low reset
//           W_*                  writeback pipeline register contents
//           d_srcA/B, d_rvalA/B  decode read ports (0xF reads as 0)
//           Stat, halted         processor status and sticky stop flag
//           retired              saturating count of committed AOK instrs
module wb_regfile_unit #(
  parameter int                DATA_W    = 64,
  parameter int                CNT_W     = 32,
  parameter logic [DATA_W-1:0] RSP_RESET = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        W_stat,
  input  logic [3:0]        W_icode,
  input  logic [DATA_W-1:0] W_valE,
  input  logic [DATA_W-1:0] W_valM,
  input  logic [3:0]        W_dstE,
  input  logic [3:0]        W_dstM,
  input  logic [3:0]        d_srcA,
  input  logic [3:0]        d_srcB,
  output logic [DATA_W-1:0] d_rvalA,
  output logic [DATA_W-1:0] d_rvalB,
  output logic [3:0]        Stat,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] S_AOK = 4'd1;
  localparam logic [3:0] S_HLT = 4'd2;
  localparam logic [3:0] S_ADR = 4'd3;
  localparam logic [3:0] S_INS = 4'd4;
  localparam logic [3:0] S_BUB = 4'd8;

  typedef enum logic {RUN, HALTED} state_t;

  state_t            state;
  logic [DATA_W-1:0] regs [15];
  logic [3:0]        stat_q;
  logic              halted_q;
  logic [CNT_W-1:0]  retired_q;
  logic              commit;

  // W_icode only qualifies status upstream; it never gates a write here.
  logic unused_icode;
  assign unused_icode = ^W_icode;

  assign commit = (state == RUN) && (W_stat == S_AOK);

  // Register array. When both ports target the same register (popq %rsp),
  // the memory value takes priority over the ALU value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) begin
        regs[i] <= (i == 4) ? RSP_RESET : '0;
      end
    end else if (commit) begin
      for (int i = 0; i < 15; i++) begin
        if (W_dstM == 4'(i)) begin
          regs[i] <= W_valM;
        end else if (W_dstE == 4'(i)) begin
          regs[i] <= W_valE;
        end
      end
    end
  end

  // Status FSM. HALTED is terminal until reset, and Stat/retired freeze there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      stat_q    <= S_AOK;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      case (state)
        RUN: begin
          case (W_stat)
            S_AOK: begin
              stat_q <= S_AOK;
              if (retired_q != {CNT_W{1'b1}}) begin
                retired_q <= retired_q + 1'b1;
              end
            end
            S_BUB: stat_q <= S_AOK;
            S_HLT, S_ADR, S_INS: begin
              stat_q   <= W_stat;
              halted_q <= 1'b1;
              state    <= HALTED;
            end
            // Undefined status codes are treated as an invalid instruction.
            default: begin
              stat_q   <= S_INS;
              halted_q <= 1'b1;
              state    <= HALTED;
            end
          endcase
        end
        HALTED: begin
          state <= HALTED;
        end
        default: state <= HALTED;
      endcase
    end
  end

  assign d_rvalA = (d_srcA == RNONE) ? '0 : regs[d_srcA];
  assign d_rvalB = (d_srcB == RNONE) ? '0 : regs[d_srcB];
  assign Stat    = stat_q;
  assign halted  = halted_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_wb_regfile_unit.sv
`timescale 1ns/1ps
module tb_wb_regfile_unit;

  localparam int                DATA_W = 64;
  localparam int                CNT_W  = 4;
  localparam logic [DATA_W-1:0] RSP_RV = 64'h0000_0000_0000_F000;

  localparam int K_REG  = 0;  // read a register through d_srcB
  localparam int K_RVA  = 1;  // d_rvalA with the current d_srcA
  localparam int K_RET  = 2;
  localparam int K_STAT = 3;
  localparam int K_HALT = 4;

  typedef struct {
    string       tag;
    int          kind;
    logic [3:0]  idx;
    logic [63:0] val;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        W_stat, W_icode, W_dstE, W_dstM, d_srcA, d_srcB;
  logic [DATA_W-1:0] W_valE, W_valM;
  logic [DATA_W-1:0] d_rvalA, d_rvalB;
  logic [3:0]        Stat;
  logic              halted;
  logic [CNT_W-1:0]  retired;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #10 clk = ~clk;

  wb_regfile_unit #(.DATA_W(DATA_W), .CNT_W(CNT_W), .RSP_RESET(RSP_RV)) dut (
    .clk(clk), .rst_n(rst_n),
    .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
    .Stat(Stat), .halted(halted), .retired(retired)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int kind, input logic [3:0] idx, input logic [63:0] val);
    exp_t e;
    e.tag = tag; e.kind = kind; e.idx = idx; e.val = val;
    sb.push_back(e);
  endtask

  task automatic exp_reg(input string tag, input logic [3:0] r, input logic [63:0] v);
    push(tag, K_REG, r, v);
  endtask

  task automatic exp_state(input string tag, input logic [3:0] st, input logic h, input int ret);
    push({tag, "_stat"}, K_STAT, 4'h0, 64'(st));
    push({tag, "_halt"}, K_HALT, 4'h0, 64'(h));
    push({tag, "_ret"},  K_RET,  4'h0, 64'(ret));
  endtask

  // Pop every pending expectation and compare it against the DUT.
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_REG: begin
          d_srcB = e.idx;
          #1;
          check_val(e.tag, d_rvalB, e.val);
        end
        K_RVA:  check_val(e.tag, d_rvalA, e.val);
        K_RET:  check_val(e.tag, 64'(retired), e.val);
        K_STAT: check_val(e.tag, 64'(Stat), e.val);
        default: check_val(e.tag, 64'(halted), e.val);
      endcase
    end
  endtask

  task automatic drive(input logic [3:0] st, input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm);
    W_stat = st; W_dstE = de; W_valE = ve; W_dstM = dm; W_valM = vm;
    W_icode = 4'h1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(4'd8, 4'hF, '0, 4'hF, '0);
    #2;
    exp_state("rst", 4'd1, 1'b0, 0);
    exp_reg("rst_r4", 4'd4, RSP_RV);
    exp_reg("rst_r3", 4'd3, 64'h0);
    exp_reg("rst_r5", 4'd5, 64'h0);
    drain();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    d_srcA = 4'hF; d_srcB = 4'hF;
    drive(4'd8, 4'hF, '0, 4'hF, '0);
    do_reset();

    // Plain valE write.
    drive(4'd1, 4'd3, 64'h1122334455667788, 4'hF, 64'hDEAD);
    exp_reg("w_r3", 4'd3, 64'h1122334455667788);
    exp_state("w1", 4'd1, 1'b0, 1);
    tick();

    // Same destination on both ports: valM wins.
    drive(4'd1, 4'd4, 64'h100, 4'd4, 64'h200);
    exp_reg("pop_r4", 4'd4, 64'h200);
    exp_state("pop", 4'd1, 1'b0, 2);
    tick();

    // Boundary registers 0 and 14 on separate ports.
    drive(4'd1, 4'd14, 64'hE, 4'd0, 64'hD);
    exp_reg("r14", 4'd14, 64'hE);
    exp_reg("r0", 4'd0, 64'hD);
    exp_reg("r4_keep", 4'd4, 64'h200);
    exp_state("edge", 4'd1, 1'b0, 3);
    tick();

    // A same-cycle read returns the old value; RNONE reads as zero.
    d_srcA = 4'd5; d_srcB = 4'hF;
    drive(4'd1, 4'd5, 64'h55, 4'hF, 64'h0);
    #1;
    check_val("pre_rvalA", d_rvalA, 64'h0);
    check_val("rnone_rvalB", d_rvalB, 64'h0);
    push("post_rvalA", K_RVA, 4'd5, 64'h55);
    exp_state("byp", 4'd1, 1'b0, 4);
    tick();

    // Bubbles write nothing and are not counted.
    for (int i = 0; i < 2; i++) begin
      drive(4'd8, 4'd2, 64'hAA, 4'hF, 64'h0);
      exp_reg("bub_r2", 4'd2, 64'h0);
      exp_state("bub", 4'd1, 1'b0, 4);
      tick();
    end

    // HLT stops the machine without writing.
    drive(4'd2, 4'd2, 64'h9, 4'hF, 64'h0);
    exp_reg("hlt_r2", 4'd2, 64'h0);
    exp_state("hlt", 4'd2, 1'b1, 4);
    tick();

    // While halted, AOK and other status codes change nothing.
    drive(4'd1, 4'd6, 64'h66, 4'd7, 64'h77);
    exp_reg("hw_r6", 4'd6, 64'h0);
    exp_reg("hw_r7", 4'd7, 64'h0);
    exp_state("hw", 4'd2, 1'b1, 4);
    tick();
    drive(4'd3, 4'hF, 64'h0, 4'hF, 64'h0);
    exp_state("hw2", 4'd2, 1'b1, 4);
    tick();

    // ADR then an asynchronous reset in mid-cycle.
    do_reset();
    drive(4'd3, 4'd7, 64'h77, 4'hF, 64'h0);
    exp_reg("adr_r7", 4'd7, 64'h0);
    exp_state("adr", 4'd3, 1'b1, 0);
    tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_state("arst", 4'd1, 1'b0, 0);
    exp_reg("arst_r4", 4'd4, RSP_RV);
    exp_reg("arst_r3", 4'd3, 64'h0);
    drain();
    @(negedge clk);
    rst_n = 1'b1;

    // An undefined status code is treated as INS.
    drive(4'd5, 4'd1, 64'h11, 4'hF, 64'h0);
    exp_reg("bad_r1", 4'd1, 64'h0);
    exp_state("bad", 4'd4, 1'b0 ^ 1'b1, 0);
    tick();

    // INS from a fresh start.
    do_reset();
    drive(4'd4, 4'd1, 64'h11, 4'hF, 64'h0);
    exp_state("ins", 4'd4, 1'b1, 0);
    tick();

    // Counter saturation with CNT_W=4: nops count and hold at 15.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(4'd1, 4'hF, 64'h1, 4'hF, 64'h2);
      push("sat_ret", K_RET, 4'h0, 64'((i + 1 > 15) ? 15 : i + 1));
      push("sat_stat", K_STAT, 4'h0, 64'd1);
      tick();
    end
    exp_reg("sat_r4", 4'd4, RSP_RV);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
